// File: rtl/conv_layer_multi.sv
// conv_layer_multi: K-filter, D-channel convolution layer. P sliding-window
// positions of one output row are evaluated together, each as a sequential
// multiply-accumulate over D*F*F taps. The results are written into a flat
// output bus that holds its value between runs.
module conv_layer_multi #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC       = 8,
    parameter int D          = 1,
    parameter int H          = 32,
    parameter int W          = 32,
    parameter int F          = 5,
    parameter int K          = 2,
    parameter int P          = 4,
    parameter int STRIDE     = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic [0:D*H*W*DATA_WIDTH-1] image,
    input  logic [0:K*D*F*F*DATA_WIDTH-1] filter,
    output logic busy,
    output logic done,
    output logic [0:K*((H-F)/STRIDE+1)*((W-F)/STRIDE+1)*DATA_WIDTH-1] outputConv
);

    localparam int OH     = (H - F) / STRIDE + 1;
    localparam int OW     = (W - F) / STRIDE + 1;
    localparam int N      = D * F * F;
    localparam int AW     = 2 * DATA_WIDTH + $clog2(N);
    localparam int TW     = (N > 1) ? $clog2(N) + 1 : 1;
    localparam int FW     = (F > 1) ? $clog2(F) : 1;
    localparam int DIDX_W = (D > 1) ? $clog2(D) : 1;
    localparam int RW     = $clog2(OH + 1) + 1;
    localparam int CW     = $clog2(OW + P) + 1;

    localparam logic [TW-1:0]     T_LAST = TW'(N - 1);
    localparam logic [FW-1:0]     F_LAST = FW'(F - 1);
    localparam logic [DIDX_W-1:0] D_LAST = DIDX_W'(D - 1);
    localparam logic [RW-1:0]     R_LAST = RW'(OH - 1);
    localparam logic [CW-1:0]     OW_C   = CW'(OW);
    localparam logic [CW-1:0]     P_C    = CW'(P);

    // Saturation bounds expressed at accumulator width.
    localparam logic signed [AW-1:0] MAX_A = {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] MIN_A = {{(AW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] MAX_W = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_W = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_MAC   = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state_r;
    state_t next_s;

    logic [TW-1:0]     t_r;
    logic [FW-1:0]     fx_r;
    logic [FW-1:0]     fy_r;
    logic [DIDX_W-1:0] d_r;
    logic [RW-1:0]     r_r;
    logic [CW-1:0]     c0_r;
    logic              busy_r;
    logic              done_r;
    logic              last_s;
    logic [0:K*OH*OW*DATA_WIDTH-1] out_r;

    logic signed [AW-1:0]           acc_r  [P][K];
    logic signed [DATA_WIDTH-1:0]   pix_s  [P];
    logic signed [DATA_WIDTH-1:0]   wgt_s  [K];
    logic signed [2*DATA_WIDTH-1:0] prod_s [P][K];

    // Floor-shift by FRAC (arithmetic shift rounds toward -inf), then clamp.
    function automatic logic [DATA_WIDTH-1:0] sat_word(input logic signed [AW-1:0] acc);
        logic signed [AW-1:0] sh;
        sh = acc >>> FRAC;
        if (sh > MAX_A) begin
            sat_word = MAX_W;
        end else if (sh < MIN_A) begin
            sat_word = MIN_W;
        end else begin
            sat_word = sh[DATA_WIDTH-1:0];
        end
    endfunction

    assign busy       = busy_r;
    assign done       = done_r;
    assign outputConv = out_r;

    // The group just written is the final one when it sits on the last row
    // and the next column step would run past the row end.
    assign last_s = (r_r == R_LAST) && ((c0_r + P_C) >= OW_C);

    // State register plus registered handshake outputs derived from next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= next_s;
            busy_r  <= (next_s != S_IDLE);
            done_r  <= (next_s == S_DONE);
        end
    end

    // Next-state decode for the run sequencer.
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    next_s = S_CLEAR;
                end else begin
                    next_s = S_IDLE;
                end
            end
            S_CLEAR: next_s = S_MAC;
            S_MAC: begin
                if (t_r == T_LAST) begin
                    next_s = S_WRITE;
                end else begin
                    next_s = S_MAC;
                end
            end
            S_WRITE: begin
                if (last_s) begin
                    next_s = S_DONE;
                end else begin
                    next_s = S_CLEAR;
                end
            end
            S_DONE:  next_s = S_IDLE;
            default: next_s = S_IDLE;
        endcase
    end

    // Fetch the current tap's pixel per lane and weight per filter, and form
    // the full-width products. Lanes past the right image edge see zero.
    always_comb begin
        int col;
        int row;
        col = 0;
        row = int'(r_r) * STRIDE + int'(fy_r);
        for (int p = 0; p < P; p++) begin
            pix_s[p] = '0;
            col = (int'(c0_r) + p) * STRIDE + int'(fx_r);
            if (col < W) begin
                pix_s[p] = image[((int'(d_r) * H + row) * W + col) * DATA_WIDTH +: DATA_WIDTH];
            end else begin
                pix_s[p] = '0;
            end
        end
        for (int k = 0; k < K; k++) begin
            wgt_s[k] = filter[(((k * D + int'(d_r)) * F + int'(fy_r)) * F + int'(fx_r)) * DATA_WIDTH +: DATA_WIDTH];
        end
        for (int p = 0; p < P; p++) begin
            for (int k = 0; k < K; k++) begin
                prod_s[p][k] = pix_s[p] * wgt_s[k];
            end
        end
    end

    // Datapath: tap counters, accumulators, group pointer and output words.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t_r   <= '0;
            fx_r  <= '0;
            fy_r  <= '0;
            d_r   <= '0;
            r_r   <= '0;
            c0_r  <= '0;
            out_r <= '0;
            for (int p = 0; p < P; p++) begin
                for (int k = 0; k < K; k++) begin
                    acc_r[p][k] <= '0;
                end
            end
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        r_r  <= '0;
                        c0_r <= '0;
                    end
                end
                S_CLEAR: begin
                    t_r  <= '0;
                    fx_r <= '0;
                    fy_r <= '0;
                    d_r  <= '0;
                    for (int p = 0; p < P; p++) begin
                        for (int k = 0; k < K; k++) begin
                            acc_r[p][k] <= '0;
                        end
                    end
                end
                S_MAC: begin
                    for (int p = 0; p < P; p++) begin
                        for (int k = 0; k < K; k++) begin
                            acc_r[p][k] <= acc_r[p][k] + AW'(prod_s[p][k]);
                        end
                    end
                    t_r <= t_r + 1'b1;
                    // Tap order: fx fastest, then fy, then channel.
                    if (fx_r == F_LAST) begin
                        fx_r <= '0;
                        if (fy_r == F_LAST) begin
                            fy_r <= '0;
                            if (d_r == D_LAST) begin
                                d_r <= '0;
                            end else begin
                                d_r <= d_r + 1'b1;
                            end
                        end else begin
                            fy_r <= fy_r + 1'b1;
                        end
                    end else begin
                        fx_r <= fx_r + 1'b1;
                    end
                end
                S_WRITE: begin
                    for (int p = 0; p < P; p++) begin
                        for (int k = 0; k < K; k++) begin
                            if ((c0_r + CW'(p)) < OW_C) begin
                                out_r[((k * OH + int'(r_r)) * OW + int'(c0_r) + p) * DATA_WIDTH +: DATA_WIDTH]
                                    <= sat_word(acc_r[p][k]);
                            end
                        end
                    end
                    if ((c0_r + P_C) >= OW_C) begin
                        c0_r <= '0;
                        r_r  <= r_r + 1'b1;
                    end else begin
                        c0_r <= c0_r + P_C;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
